// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory request controller.
// Optional feature macro used by the block: DMEM_UNCACHED_OUT_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // kseg0 spans nibbles 0x8..0x9, kseg1 (uncached) spans 0xA..0xB
  localparam logic [3:0] KSEG0_LO = 4'h8;
  localparam logic [3:0] KSEG1_LO = 4'hA;
  localparam logic [3:0] KSEG1_HI = 4'hB;

  function automatic logic [1:0] size_from_ones(input int unsigned ones);
    logic [1:0] code;
    case (ones)
      1:       code = SIZE_B;
      2:       code = SIZE_H;
      default: code = SIZE_W;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// SRAM-like data bus (req / addr_ok / data_ok); master is the controller.
// DMEM_UNCACHED_OUT_EN adds the mem_uncached request attribute.
interface dmem_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int BEN_W = DATA_W / 8;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [BEN_W-1:0]  mem_ben;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_UNCACHED_OUT_EN
  logic              mem_uncached;
`endif

  modport master (
    output mem_req, mem_wr, mem_size, mem_ben, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
`ifdef DMEM_UNCACHED_OUT_EN
    , output mem_uncached
`endif
  );

  modport slave (
    input  mem_req, mem_wr, mem_size, mem_ben, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
`ifdef DMEM_UNCACHED_OUT_EN
    , input mem_uncached
`endif
  );

endinterface

// File: rtl/dmem_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
// DMEM_UNCACHED_OUT_EN adds the kseg1 uncached flag output.
module dmem_addr_map
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
`ifdef DMEM_UNCACHED_OUT_EN
  , output logic            uncached
`endif
);

  logic [3:0] seg;
  logic       kseg;

  assign seg  = vaddr[ADDR_W-1 -: 4];
  assign kseg = (seg >= KSEG0_LO) && (seg <= KSEG1_HI);

  // kseg0/kseg1 both alias the low 512 MB window of physical memory
  always_comb begin
    paddr = vaddr;
    if (kseg) begin
      paddr[ADDR_W-1 -: 3] = 3'b000;
    end
  end

`ifdef DMEM_UNCACHED_OUT_EN
  assign uncached = (seg >= KSEG1_LO) && (seg <= KSEG1_HI);
`endif

endmodule

// File: rtl/dmem_req_ctrl.sv
// Registered M-stage data-memory port: holds the request until addr_ok, stalls until data_ok.
// DMEM_UNCACHED_OUT_EN adds bus.mem_uncached, latched with each request.
module dmem_req_ctrl
  import dmem_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BEN_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [BEN_W-1:0]  selM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              flushM,
  input  logic              core_ready,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  dmem_req_ctrl_if.master   bus
);

  logic [ADDR_W-1:0] paddr;
  logic [1:0]        size_next;
  logic              issue;

  state_t            state_reg;
  logic              discard_reg;
  logic              mem_req_reg;
  logic              mem_wr_reg;
  logic [1:0]        mem_size_reg;
  logic [BEN_W-1:0]  mem_ben_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] readdata_reg;

`ifdef DMEM_UNCACHED_OUT_EN
  logic              uncached;
  logic              uncached_reg;
`endif

  dmem_addr_map #(
    .ADDR_W (ADDR_W)
  ) u_addr_map (
    .vaddr    (aluoutM),
    .paddr    (paddr)
`ifdef DMEM_UNCACHED_OUT_EN
    , .uncached (uncached)
`endif
  );

  assign issue     = memenM && !flushM;
  assign size_next = size_from_ones($countones(selM));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      discard_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_size_reg  <= SIZE_B;
      mem_ben_reg   <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      readdata_reg  <= '0;
`ifdef DMEM_UNCACHED_OUT_EN
      uncached_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            mem_req_reg   <= 1'b1;
            mem_wr_reg    <= memwriteM;
            mem_size_reg  <= size_next;
            mem_ben_reg   <= selM;
            mem_addr_reg  <= paddr;
            mem_wdata_reg <= writedataM;
`ifdef DMEM_UNCACHED_OUT_EN
            uncached_reg  <= uncached;
`endif
            state_reg     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // once accepted, a flushed request must still drain its response
          if (bus.mem_addr_ok) begin
            mem_req_reg <= 1'b0;
            discard_reg <= flushM;
            state_reg   <= ST_WAIT;
          end else if (flushM) begin
            mem_req_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_data_ok) begin
            if (discard_reg || flushM) begin
              discard_reg <= 1'b0;
              state_reg   <= ST_IDLE;
            end else begin
              if (!mem_wr_reg) begin
                readdata_reg <= bus.mem_rdata;
              end
              state_reg <= ST_DONE;
            end
          end else if (flushM) begin
            discard_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          // memenM is still high for the same instruction here; only advance/flush leaves
          if (core_ready || flushM) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign stallM = ((state_reg == ST_IDLE) && issue) ||
                  (state_reg == ST_REQ) || (state_reg == ST_WAIT);

  assign readdataM     = readdata_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_wr    = mem_wr_reg;
  assign bus.mem_size  = mem_size_reg;
  assign bus.mem_ben   = mem_ben_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
`ifdef DMEM_UNCACHED_OUT_EN
  assign bus.mem_uncached = uncached_reg;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: vector table, corner sequences, random transactions.
// Define DMEM_UNCACHED_OUT_EN to also check mem_uncached.
module tb_dmem_req_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          memenM, memwriteM, flushM, core_ready;
  logic [BW-1:0] selM;
  logic [AW-1:0] aluoutM;
  logic [DW-1:0] writedataM;
  logic [DW-1:0] readdataM;
  logic          stallM;
  logic          addr_ok, data_ok;
  logic [DW-1:0] rdata_drv;

  int            tests = 0;
  int            fails = 0;
  int            txn_no = 0;
  logic [DW-1:0] exp_rd;

  always #5 clk = ~clk;

  dmem_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.mem_addr_ok = addr_ok;
  assign bus.mem_data_ok = data_ok;
  assign bus.mem_rdata   = rdata_drv;

  dmem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .selM       (selM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .core_ready (core_ready),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .bus        (bus.master)
  );

  typedef struct {
    logic [31:0] va;
    logic [3:0]  sel;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] pa;
    logic [1:0]  sz;
    logic        unc;
    int          alat;
    int          dlat;
    logic [31:0] rd;
    int          hold;
  } vec_t;

  vec_t        tbl [9];
  logic [3:0]  sels [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE is the only state with stallM following memenM; no edge passes here
  task automatic check_idle(input string tag);
    chk({tag, "_idle_req"}, bus.mem_req, 1'b0);
    memenM = 1'b0; flushM = 1'b0;
    #1 chk({tag, "_idle_stall_off"}, stallM, 1'b0);
    memenM = 1'b1;
    #1 chk({tag, "_idle_stall_on"}, stallM, 1'b1);
    memenM = 1'b0;
    #1;
  endtask

  // Reference rules: kseg0/kseg1 fold onto the low 512 MB, size from byte-enable count
  function automatic logic [31:0] ref_xlate(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va % 32'h2000_0000;
    return va;
  endfunction

  function automatic logic ref_unc(input logic [31:0] va);
    return (va >= 32'hA000_0000 && va < 32'hC000_0000);
  endfunction

  function automatic logic [1:0] ref_size(input logic [3:0] sel);
    int n = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) n++;
    if (n == 1) return 2'd0;
    if (n == 2) return 2'd1;
    return 2'd2;
  endfunction

  // fmode: 0 = normal, 1 = flush in REQ before addr_ok, 2 = flush in WAIT (drain)
  task automatic do_txn(input logic [31:0] va, input logic [3:0] sel, input logic wr,
                        input logic [31:0] wd, input logic [31:0] exp_pa,
                        input logic [1:0] exp_sz, input logic exp_unc,
                        input int alat, input int dlat, input int fmode,
                        input logic [31:0] rd, input int hold, input logic adv_flush);
    txn_no++;
    $display("[TB] txn %0d va=%h sel=%h wr=%0d pa=%h sz=%0d unc=%0d alat=%0d dlat=%0d fmode=%0d",
             txn_no, va, sel, wr, exp_pa, exp_sz, exp_unc, alat, dlat, fmode);
    memenM = 1'b1; memwriteM = wr; selM = sel; aluoutM = va; writedataM = wd;
    flushM = 1'b0; core_ready = 1'b0;
    #1 chk("issue_stall", stallM, 1'b1);
    tick();
    chk("req_valid", bus.mem_req, 1'b1);
    chk("req_addr", bus.mem_addr, exp_pa);
    chk("req_size", bus.mem_size, exp_sz);
    chk("req_ben", bus.mem_ben, sel);
    chk("req_wr", bus.mem_wr, wr);
    chk("req_wdata", bus.mem_wdata, wd);
`ifdef DMEM_UNCACHED_OUT_EN
    chk("req_uncached", bus.mem_uncached, exp_unc);
`endif
    chk("req_stall", stallM, 1'b1);
    // CPU-side fields may change while the request is pending
    aluoutM = $urandom; selM = 4'($urandom); writedataM = $urandom; memwriteM = ~wr;
    for (int i = 0; i < alat; i++) begin
      tick();
      chk("req_hold_valid", bus.mem_req, 1'b1);
      chk("req_hold_addr", bus.mem_addr, exp_pa);
      chk("req_hold_wdata", bus.mem_wdata, wd);
      chk("req_hold_stall", stallM, 1'b1);
    end
    if (fmode == 1) begin
      flushM = 1'b1;
      tick();
      flushM = 1'b0; memenM = 1'b0;
      #1 chk("flushreq_req", bus.mem_req, 1'b0);
      chk("flushreq_stall", stallM, 1'b0);
      check_idle("flushreq");
      chk("flushreq_rdata", readdataM, exp_rd);
      return;
    end
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("wait_req", bus.mem_req, 1'b0);
    chk("wait_stall", stallM, 1'b1);
    if (fmode == 2) begin
      flushM = 1'b1; memenM = 1'b0;
      rdata_drv = $urandom;
      tick();
      flushM = 1'b0;
      // next instruction's load arrives but must wait for the drain
      memenM = 1'b1; aluoutM = $urandom;
      for (int i = 1; i < dlat; i++) begin
        rdata_drv = $urandom;
        tick();
        chk("drain_noreq", bus.mem_req, 1'b0);
        chk("drain_stall", stallM, 1'b1);
      end
    end else begin
      for (int i = 0; i < dlat; i++) begin
        rdata_drv = $urandom;
        tick();
        chk("wait_hold_stall", stallM, 1'b1);
        chk("wait_hold_rdata", readdataM, exp_rd);
      end
    end
    data_ok = 1'b1; rdata_drv = rd;
    tick();
    data_ok = 1'b0; rdata_drv = $urandom;
    if (fmode == 2) begin
      chk("drain_rdata", readdataM, exp_rd);
      check_idle("drain");
      return;
    end
    if (!wr) exp_rd = rd;
    chk("done_rdata", readdataM, exp_rd);
    chk("done_stall", stallM, 1'b0);
    chk("done_req", bus.mem_req, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("done_hold_req", bus.mem_req, 1'b0);
      chk("done_hold_stall", stallM, 1'b0);
      chk("done_hold_rdata", readdataM, exp_rd);
    end
    if (adv_flush) flushM = 1'b1; else core_ready = 1'b1;
    tick();
    core_ready = 1'b0; flushM = 1'b0; memenM = 1'b0;
    check_idle("advance");
    chk("advance_rdata", readdataM, exp_rd);
  endtask

  initial begin
    tbl[0] = '{32'h8000_1000, 4'hF, 1'b0, 32'h0,         32'h0000_1000, 2'd2, 1'b0, 2, 3, 32'hDEAD_BEEF, 0};
    tbl[1] = '{32'hBFC0_0003, 4'h8, 1'b1, 32'h1100_0000, 32'h1FC0_0003, 2'd0, 1'b1, 0, 1, 32'h5555_5555, 0};
    tbl[2] = '{32'hA000_0010, 4'h3, 1'b0, 32'h0,         32'h0000_0010, 2'd1, 1'b1, 1, 0, 32'h0102_0304, 4};
    tbl[3] = '{32'h7FFF_FFFC, 4'hF, 1'b0, 32'h0,         32'h7FFF_FFFC, 2'd2, 1'b0, 0, 0, 32'h1357_9BDF, 0};
    tbl[4] = '{32'hC000_0004, 4'hC, 1'b1, 32'hAABB_0000, 32'hC000_0004, 2'd1, 1'b0, 1, 2, 32'h0,         0};
    tbl[5] = '{32'h9123_4568, 4'h1, 1'b0, 32'h0,         32'h1123_4568, 2'd0, 1'b0, 0, 1, 32'h0000_00A5, 0};
    tbl[6] = '{32'h0000_0000, 4'h7, 1'b0, 32'h0,         32'h0000_0000, 2'd2, 1'b0, 3, 0, 32'hFFFF_0000, 0};
    tbl[7] = '{32'hA000_0000, 4'hF, 1'b0, 32'h0,         32'h0000_0000, 2'd2, 1'b1, 0, 1, 32'h0BAD_F00D, 0};
    tbl[8] = '{32'h8000_0000, 4'hF, 1'b0, 32'h0,         32'h0000_0000, 2'd2, 1'b0, 0, 1, 32'h600D_CAFE, 0};
    sels = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h7};

    resetn = 1'b0; memenM = 1'b0; memwriteM = 1'b0; selM = '0; aluoutM = '0;
    writedataM = '0; flushM = 1'b0; core_ready = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata_drv = '0; exp_rd = '0;
    repeat (3) tick();
    chk("rst_rdata", readdataM, 32'h0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_wr", bus.mem_wr, 1'b0);
    chk("rst_size", bus.mem_size, 2'd0);
    chk("rst_ben", bus.mem_ben, 4'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_stall", stallM, 1'b0);
    resetn = 1'b1;
    tick();

    // data_ok with nothing outstanding is ignored
    data_ok = 1'b1; rdata_drv = 32'hFEED_FACE;
    tick();
    data_ok = 1'b0;
    chk("stray_idle_rdata", readdataM, exp_rd);
    check_idle("stray_idle");

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].va, tbl[i].sel, tbl[i].wr, tbl[i].wd, tbl[i].pa, tbl[i].sz, tbl[i].unc,
             tbl[i].alat, tbl[i].dlat, 0, tbl[i].rd, tbl[i].hold, 1'b0);

    // flush before acceptance, flush while waiting, then a clean load after the drain
    do_txn(32'h8000_2000, 4'hF, 1'b0, 32'h0, 32'h0000_2000, 2'd2, 1'b0, 1, 0, 1, 32'h0, 0, 1'b0);
    do_txn(32'h8000_3000, 4'hF, 1'b0, 32'h0, 32'h0000_3000, 2'd2, 1'b0, 0, 2, 2, 32'h1234_5678, 0, 1'b0);
    do_txn(32'h0040_0000, 4'hF, 1'b0, 32'h0, 32'h0040_0000, 2'd2, 1'b0, 0, 1, 0, 32'h89AB_CDEF, 0, 1'b1);

    // asynchronous reset while waiting, then a stray response after release
    memenM = 1'b1; memwriteM = 1'b0; selM = 4'hF; aluoutM = 32'h8000_4000;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; memenM = 1'b0;
    #1 chk("prerst_wait_stall", stallM, 1'b1);
    resetn = 1'b0;
    #1;
    exp_rd = '0;
    chk("midrst_rdata", readdataM, exp_rd);
    chk("midrst_req", bus.mem_req, 1'b0);
    chk("midrst_addr", bus.mem_addr, 32'h0);
    chk("midrst_stall", stallM, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    data_ok = 1'b1; rdata_drv = 32'hCAFE_0001;
    tick();
    data_ok = 1'b0;
    chk("postrst_rdata", readdataM, exp_rd);
    check_idle("postrst");

    // randomized transactions against the reference rules
    for (int n = 0; n < 40; n++) begin
      logic [31:0] va, wd, rd;
      logic [3:0]  sel;
      logic        wr, af;
      int          fm, al, dl;
      va  = $urandom; wd = $urandom; rd = $urandom;
      sel = sels[$urandom_range(0, 7)];
      wr  = 1'($urandom_range(0, 1));
      af  = 1'($urandom_range(0, 1));
      al  = $urandom_range(0, 3);
      dl  = $urandom_range(0, 3);
      fm  = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0);
      if (fm == 2 && dl == 0) dl = 1;
      do_txn(va, sel, wr, wd, ref_xlate(va), ref_size(sel), ref_unc(va),
             al, dl, fm, rd, $urandom_range(0, 2), af);
      if ($urandom_range(0, 3) == 0) begin
        data_ok = 1'b1; rdata_drv = $urandom;
        tick();
        data_ok = 1'b0;
        chk("rand_stray_rdata", readdataM, exp_rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Sequential data-memory port between the CPU M stage and an SRAM-like bus with a req / addr_ok / data_ok handshake.
- Replaces the purely combinational port: it registers each request, holds it until the bus accepts it, and stalls the pipeline until data returns.
- Latches read data until the pipeline advances, discards responses to flushed instructions, and performs kseg address translation.
- Generalised in address and data width.

Parameters:
- ADDR_W, 32, address width; must be ≥ 32 (segment decode uses bits [ADDR_W-1:ADDR_W-4]).
- DATA_W, 32, data width; a power of two, multiple of 8, ≥ 32; derived BEN_W = DATA_W/8.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- memenM  in  1  M-stage memory access valid.
- memwriteM  in  1  1 = store, 0 = load.
- selM  in  BEN_W  byte enables.
- aluoutM  in  ADDR_W  virtual address.
- writedataM  in  DATA_W  store data.
- flushM  in  1  exception/flush of the M-stage instruction.
- core_ready  in  1  M stage advances this cycle.
- readdataM  out  DATA_W  load data, registered.
- stallM  out  1  stall request to the pipeline.
- mem_req  out  1  bus request.
- mem_wr  out  1  bus write.
- mem_size  out  2  0 = byte, 1 = half, 2 = word.
- mem_ben  out  BEN_W  bus byte enables.
- mem_addr  out  ADDR_W  physical address.
- mem_wdata  out  DATA_W  bus write data.
- mem_addr_ok  in  1  request accepted.
- mem_data_ok  in  1  response / write done.
- mem_rdata  in  DATA_W  response data.

Behaviour:
- Reset is asynchronous on resetn low. State = IDLE; discard = 0; all outputs 0 (readdataM included).
- States: IDLE, REQ, WAIT, DONE, with 2-bit encoding in the shared package.
- IDLE:
  - If memenM && !flushM: latch mem_wr = memwriteM, mem_ben = selM, mem_size, translated mem_addr, mem_wdata = writedataM. Go to REQ.
  - mem_data_ok in IDLE is ignored.
- REQ:
  - mem_req = 1 and all request fields are held stable.
  - addr_ok && !flushM: go to WAIT.
  - addr_ok && flushM: go to WAIT with discard = 1 (the accepted transaction must drain).
  - !addr_ok && flushM: drop the request and go to IDLE; mem_req is 0 next cycle.
  - mem_data_ok is never sampled in REQ; a response requires a prior addr_ok.
- WAIT:
  - mem_req = 0.
  - flushM sets discard.
  - On data_ok with discard = 0: readdataM <= mem_rdata (loads only; stores leave readdataM unchanged). Go to DONE.
  - On data_ok with discard = 1: clear discard and go to IDLE.
- DONE:
  - readdataM is valid and stallM = 0.
  - core_ready or flushM: go to IDLE.
  - Otherwise hold. The still-asserted memenM of the same instruction must not reissue.
- stallM = (IDLE && memenM && !flushM) || REQ || WAIT.
- Latency: a load with addr_ok in the first REQ cycle and data_ok N cycles later is in DONE after 1 + 1 + N cycles. Stall is deasserted from the DONE cycle.
- Address translation on the top 4 bits:
  - 0x8, 0x9, 0xA, 0xB (kseg0/kseg1): clear bits [ADDR_W-1:ADDR_W-3].
  - Otherwise pass through unchanged.
- mem_size is derived from the popcount of selM: 1 → 0, 2 → 1, otherwise → 2.
- Reset mid-transaction returns to IDLE immediately. Any later data_ok is ignored.

Optional Feature:
- Macro DMEM_UNCACHED_OUT_EN.
- Defined: adds output mem_uncached (1 bit), latched with the request. It is 1 when the top nibble is 0xA or 0xB and is held through REQ.
- Undefined: the port does not exist; no other behaviour changes.

Decomposition:
- Shared package dmem_pkg holds:
  - state typedef and encodings;
  - size codes SIZE_B, SIZE_H, SIZE_W;
  - segment nibble constants KSEG0_LO = 4'h8, KSEG1_HI = 4'hB.
- One sub-module: dmem_addr_map (combinational address translation + uncached flag), parametrised by ADDR_W.

Test Plan:
- Load from 0x8000_1000, sel 4'hF, addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEAD_BEEF.
  - Expect mem_addr 0x0000_1000, size 2, stallM high throughout, readdataM 0xDEAD_BEEF in DONE, stall low, IDLE on core_ready.
- Store byte to 0xBFC0_0003, sel 4'h8, data 0x1100_0000.
  - Expect mem_wr 1, mem_ben 4'h8, size 0, mem_addr 0x1FC0_0003; readdataM unchanged.
- flushM in REQ before addr_ok → mem_req low the next cycle, state IDLE, stallM 0.
- flushM in WAIT, then data_ok 0x1234_5678 → readdataM unchanged, no DONE.
  - A following load issues only after the drain completes.
- DONE held 4 cycles with core_ready 0 → no second mem_req, readdataM stable.
- resetn low during WAIT, then a stray data_ok after release → outputs 0, state stays IDLE.
- With DMEM_UNCACHED_OUT_EN defined: 0xA000_0000 → mem_uncached 1; 0x8000_0000 → mem_uncached 0.
